// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use and multi-cycle
// Execute stalls, branch/PC-write flushes, and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int RA_W    = 4,
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RA_W-1:0]   RA1D,
  input  logic [RA_W-1:0]   RA2D,
  input  logic [RA_W-1:0]   RA1E,
  input  logic [RA_W-1:0]   RA2E,
  input  logic [RA_W-1:0]   WA3E,
  input  logic [RA_W-1:0]   WA3M,
  input  logic [RA_W-1:0]   WA3W,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              MulStartE,
  input  logic              BranchMissedE,
  input  logic              PCWrPendingF,
  input  logic              PCSrcW,
  input  logic              CntClr,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              MulBusy,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);

  localparam int CW = $clog2(MUL_LAT) + 1;
  localparam logic [RA_W-1:0] PC_ADDR = {RA_W{1'b1}};

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             hold_s;
  logic             ldr_stall_s;

  // Operand source select; the M stage result is newer than W, so it wins.
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] ra,
                                         input logic [RA_W-1:0] wa_m,
                                         input logic            we_m,
                                         input logic [RA_W-1:0] wa_w,
                                         input logic            we_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (ra == PC_ADDR) begin
      sel = 2'b00;
    end else if (we_m && (wa_m == ra)) begin
      sel = 2'b10;
    end else if (we_w && (wa_w == ra)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign ldr_stall_s = MemtoRegE & RegWriteE & ((WA3E == RA1D) | (WA3E == RA2D));

  // Multi-cycle sequencer; the first Execute cycle is held from IDLE,
  // the rest from BUSY, and MulStartE is ignored while BUSY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (MulStartE && (MUL_LAT > 1)) begin
          hold_s  = 1'b1;
          state_d = BUSY;
          cnt_d   = CW'(MUL_LAT - 1);
        end else begin
          state_d = IDLE;
          cnt_d   = {CW{1'b0}};
        end
      end
      BUSY: begin
        if (cnt_q > CW'(1)) begin
          hold_s = 1'b1;
          cnt_d  = cnt_q - CW'(1);
        end else begin
          state_d = IDLE;
          cnt_d   = {CW{1'b0}};
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // Stall/flush/forward outputs; reset forces a quiet, flushing pipeline.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    MulBusy   = 1'b0;
    if (reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else begin
      ForwardAE = fwd_sel(RA1E, WA3M, RegWriteM, WA3W, RegWriteW);
      ForwardBE = fwd_sel(RA2E, WA3M, RegWriteM, WA3W, RegWriteW);
      StallF    = ldr_stall_s | PCWrPendingF | hold_s;
      StallD    = ldr_stall_s | hold_s;
      StallE    = hold_s;
      FlushM    = hold_s;
      FlushD    = PCWrPendingF | PCSrcW | BranchMissedE;
      FlushE    = (ldr_stall_s | BranchMissedE) & ~hold_s;
      MulBusy   = hold_s;
    end
  end

  // Saturating event counters; clear beats increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (CntClr) begin
      stall_cnt_d = {CNT_W{1'b0}};
      flush_cnt_d = {CNT_W{1'b0}};
    end else begin
      if (StallD && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
      if (FlushE && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else begin
        flush_cnt_d = flush_cnt_q;
      end
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the five-stage ARM core. It supersedes the single-cycle hazard unit and sits between controller and datapath. Beyond forwarding, load-use stalling and PC-write flushing, it adds:
- a multi-cycle Execute-unit hold sequencer (multiply/divide);
- predicted-branch-miss flushing;
- saturating stall and flush event counters.

## Interface
Parameters:
- RA_W, 4, register address width; address 2^RA_W-1 is the PC and is never forwarded.
- MUL_LAT, 3, Execute-stage residency in cycles of a multi-cycle op; must be ≥1.
- CNT_W, 16, width of each event counter.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- RA1D, RA2D  in  RA_W  source registers of the Decode instruction.
- RA1E, RA2E  in  RA_W  source registers of the Execute instruction.
- WA3E, WA3M, WA3W  in  RA_W  destination registers in E/M/W.
- RegWriteE, RegWriteM, RegWriteW  in  1  destination write enables.
- MemtoRegE  in  1  the Execute instruction is a load.
- MulStartE  in  1  the Execute instruction is a multi-cycle op.
- BranchMissedE  in  1  the predicted branch resolved wrong in E.
- PCWrPendingF  in  1  a PC write is in D, E or M.
- PCSrcW  in  1  a PC write is in W.
- CntClr  in  1  synchronous clear of both counters.
- ForwardAE, ForwardBE  out  2  operand select: 00 register file, 01 ResultW, 10 ALUOutM.
- StallF, StallD, StallE  out  1  hold F, D, E registers.
- FlushD, FlushE, FlushM  out  1  bubble into D, E, M registers.
- MulBusy  out  1  Execute is held by a multi-cycle op.
- StallCount, FlushCount  out  CNT_W  event counters.

## Operation
- Forwarding (per operand X∈{1,2}; combinational):
  - ForwardXE=10 if RegWriteM & WA3M==RAXE & RAXE≠PC.
  - Otherwise 01 if RegWriteW & WA3W==RAXE & RAXE≠PC.
  - Otherwise 00.
  - M takes priority over W.
- Load-use stall: LdrStall = MemtoRegE & RegWriteE & (WA3E==RA1D | WA3E==RA2D).
- Multi-cycle sequencer, FSM IDLE/BUSY with a down-counter cnt of width clog2(MUL_LAT)+1:
  - IDLE, MulStartE=1, MUL_LAT>1: Hold=1; next state BUSY with cnt=MUL_LAT-1.
  - BUSY, cnt>1: Hold=1; cnt decrements.
  - BUSY, cnt==1: Hold=0; the instruction leaves E at the clock edge; next state IDLE with cnt=0.
  - MulStartE is ignored in BUSY, because the held instruction still drives it.
  - With MUL_LAT=1, Hold is constant 0.
  - MulBusy = Hold.
- Stall/flush equations:
  - StallF = LdrStall | PCWrPendingF | Hold.
  - StallD = LdrStall | Hold.
  - StallE = Hold.
  - FlushM = Hold.
  - FlushD = PCWrPendingF | PCSrcW | BranchMissedE.
  - FlushE = (LdrStall | BranchMissedE) & ~Hold.
- Priority: a flush overrides a stall on the same register (the datapath clears the register when both are set).
- Counters:
  - StallCount +1 on each cycle with StallD=1.
  - FlushCount +1 on each cycle with FlushE=1.
  - Both saturate at 2^CNT_W-1 (no wrap).
  - CntClr zeroes both counters and takes precedence over an increment in the same cycle.

## Timing
- Forwarding and all stall/flush outputs are combinational from inputs and the FSM state, with zero cycles of latency.
- A multi-cycle op occupies E for exactly MUL_LAT cycles: the first cycle is in IDLE, the remaining MUL_LAT-1 are in BUSY.
- M receives MUL_LAT-1 bubbles.
- Counters update at the clock edge; the value is visible in the following cycle.
- Reset, any cycle including mid-BUSY:
  - state→IDLE, cnt→0, counters→0.
  - While reset=1: StallF/D/E=0, FlushM=0, FlushD=FlushE=1, MulBusy=0, ForwardAE/BE=00.
  - Counters do not count during reset.
- Simultaneous events:
  - LdrStall during Hold: FlushE is suppressed and D stays stalled.
  - PCSrcW during Hold: FlushD=1 and StallD=1; the flush wins.
  - BranchMissedE cannot coincide with MulStartE (different instruction classes). If both are driven, Hold still applies and FlushE is suppressed.

## Test plan
- Forward priority: RA1E=3, WA3M=3/RegWriteM=1, WA3W=3/RegWriteW=1 → ForwardAE=10. Drop RegWriteM → 01. Set RA1E=15 → 00.
- Load-use: MemtoRegE=1, RegWriteE=1, WA3E=5, RA2D=5 → StallF=StallD=FlushE=1 for one cycle. StallCount 0→1 and FlushCount 0→1 in the next cycle.
- Multi-cycle, MUL_LAT=3: pulse MulStartE → Hold=1 for cycles t, t+1; 0 at t+2. FlushM=1 for 2 cycles. StallCount=2. With MUL_LAT=1, Hold never asserts.
- Branch miss: BranchMissedE=1 → FlushD=FlushE=1 and no stalls. PCSrcW=1 alone → FlushD=1 and FlushE=0.
- Counter saturation, CNT_W=4: hold StallD high for 20 cycles → StallCount stays 15. CntClr with StallD=1 → count 0 in the next cycle.
- Reset mid-op: assert reset at t+1 of a MUL_LAT=4 op → next cycle MulBusy=0, state IDLE, counters 0. FlushD=FlushE=1 while reset is high.
